// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one trigger/busy UART transmitter among NUM_REQ requesters.
//   Round-robin grant, locked to the owner until it sends a beat flagged last.
//   Each accepted word is pulsed into the transmitter and the block waits for
//   the transmitter's busy cycle (or a start timeout) before the next accept.
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   req_valid_in/_last_in   per-requester valid and end-of-packet flag
//   req_data_in             requester i at [i*DATA_SIZE +: DATA_SIZE]
//   req_ready_out           per-requester accept strobe (owner only, in SEND)
//   tx_data_out/trigger_out word and one-cycle start pulse to the transmitter
//   tx_busy_in              transmitter busy
//   grant_out               one-hot current owner, 0 when idle
//   timeout_err_out         sticky: busy never rose after a trigger
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_SIZE     = 8,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data_in,
  input  logic [NUM_REQ-1:0]             req_last_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic [DATA_SIZE-1:0]           tx_data_out,
  output logic                           tx_trigger_out,
  input  logic                           tx_busy_in,
  output logic [NUM_REQ-1:0]             grant_out,
  output logic                           timeout_err_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, SEND, WAIT_START, WAIT_DONE} state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       owner_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [DATA_SIZE-1:0]   data_q;
  logic                   trig_q;
  logic                   last_q;
  logic                   err_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [IDX_W-1:0]       pick;
  logic                   found;
  logic [IDX_W-1:0]       idx;
  logic                   timeout_hit;
  logic                   word_done;
  logic [DATA_SIZE-1:0]   owner_word;

  // Round-robin scan starting just after the last owner.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req_valid_in[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign owner_word  = req_data_in[32'(owner_q)*DATA_SIZE +: DATA_SIZE];
  assign timeout_hit = (32'(cnt_q) + 1) >= START_TIMEOUT;

  // A word finishes either normally (busy fell) or by start timeout; both
  // share the same release/continue path.
  assign word_done = ((state_q == WAIT_DONE) && !tx_busy_in) ||
                     ((state_q == WAIT_START) && !tx_busy_in && timeout_hit);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ARB;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      trig_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (found) begin
            owner_q <= pick;
            grant_q <= NUM_REQ'(1) << pick;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (req_valid_in[owner_q]) begin
            data_q  <= owner_word;
            trig_q  <= 1'b1;
            last_q  <= req_last_in[owner_q];
            cnt_q   <= '0;
            state_q <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (tx_busy_in) begin
            state_q <= WAIT_DONE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: ;
        default: state_q <= ARB;
      endcase

      if (word_done) begin
        if (last_q) begin
          ptr_q   <= owner_q;
          grant_q <= '0;
          state_q <= ARB;
        end else begin
          state_q <= SEND;
        end
      end
    end
  end

  assign req_ready_out   = (state_q == SEND) ? grant_q : '0;
  assign grant_out       = grant_q;
  assign tx_data_out     = data_q;
  assign tx_trigger_out  = trig_q;
  assign timeout_err_out = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues drive the DUT, a transmitter
// model answers triggers, and a scoreboard of {source, data} is checked on
// every trigger pulse.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_last  = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic             tx_busy   = 1'b0;
  logic [NR-1:0]    req_ready_out;
  logic [DW-1:0]    tx_data_out;
  logic             tx_trigger_out;
  logic [NR-1:0]    grant_out;
  logic             timeout_err_out;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .START_TIMEOUT(TO)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .req_valid_in    (req_valid),
    .req_data_in     (req_data),
    .req_last_in     (req_last),
    .req_ready_out   (req_ready_out),
    .tx_data_out     (tx_data_out),
    .tx_trigger_out  (tx_trigger_out),
    .tx_busy_in      (tx_busy),
    .grant_out       (grant_out),
    .timeout_err_out (timeout_err_out)
  );

  typedef struct packed {logic [3:0] src; logic [7:0] data;} exp_t;
  exp_t       expq[$];
  logic [8:0] rq[NR][$];

  int checks = 0;
  int fails = 0;
  int trig_cnt = 0;
  int busy_len = 20;
  bit stuck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pw(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic ex(input int s, input logic [7:0] d);
    exp_t e;
    e.src  = 4'(s);
    e.data = d;
    expq.push_back(e);
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requester driver: a word is accepted at the posedge that sees ready&valid.
  initial begin
    logic [NR-1:0] acc;
    logic [8:0]    h;
    forever begin
      @(negedge clk);
      acc = req_ready_out & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          h = rq[i][0];
          req_valid[i]          = 1'b1;
          req_last[i]           = h[8];
          req_data[i*DW +: DW]  = h[7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy rises 2 cycles after a trigger, stays busy_len cycles.
  initial begin
    int pend = 0;
    int bcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tx_busy = 1'b0; pend = 0; bcnt = 0;
      end else begin
        if (tx_busy) begin
          bcnt--;
          if (bcnt <= 0) tx_busy = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin tx_busy = 1'b1; bcnt = busy_len; end
        end
        if (tx_trigger_out && !stuck) pend = 2;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_trigger_out) begin
        trig_cnt++;
        if (expq.size() == 0) begin
          chk("spurious_trigger_pending", 32'(expq.size()), 32'd1);
        end else begin
          e = expq.pop_front();
          chk("tx_data", 32'(tx_data_out), 32'(e.data));
          chk("tx_src_grant", 32'(grant_out), 32'(1) << e.src);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_grant"}, 32'(grant_out), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready_out), 32'd0);
    chk({tag, "_trig"},  32'(tx_trigger_out), 32'd0);
    chk({tag, "_data"},  32'(tx_data_out), 32'd0);
    chk({tag, "_err"},   32'(timeout_err_out), 32'd0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    bit done = 1'b0;
    while (!done && k < limit) begin
      @(negedge clk);
      k++;
      done = (expq.size() == 0) && (grant_out == '0) && !tx_busy && rq_empty();
    end
    chk({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  initial begin
    int k;
    int t0;
    int viol;

    do_reset("rst0");

    // Single requester, latency from first visible valid to trigger.
    @(negedge clk);
    t0 = trig_cnt;
    pw(1, 8'hA5, 1'b1); ex(1, 8'hA5);
    k = 0;
    while (!req_valid[1] && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (!tx_trigger_out && k < 10) begin @(negedge clk); k++; end
    chk("t1_latency", 32'(k), 32'd2);
    chk("t1_grant", 32'(grant_out), 32'b0010);
    wait_idle("t1", 200);
    chk("t1_trig_count", 32'(trig_cnt - t0), 32'd1);
    chk("t1_grant_released", 32'(grant_out), 32'd0);
    chk("t1_err", 32'(timeout_err_out), 32'd0);

    // Round-robin from reset pointer.
    do_reset("rst1");
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      pw(i, 8'(8'h10 + i), 1'b1); ex(i, 8'(8'h10 + i));
    end
    pw(0, 8'h40, 1'b1); ex(0, 8'h40);
    wait_idle("t2", 800);

    // Packet lock: req2 three beats while req0 waits.
    @(negedge clk);
    pw(2, 8'h11, 1'b0); pw(2, 8'h22, 1'b0); pw(2, 8'h33, 1'b1);
    pw(0, 8'h55, 1'b1);
    ex(2, 8'h11); ex(2, 8'h22); ex(2, 8'h33); ex(0, 8'h55);
    wait_idle("t3", 800);

    // Busy gating with a long busy.
    busy_len = 50;
    @(negedge clk);
    t0 = trig_cnt;
    pw(3, 8'hC1, 1'b0); pw(3, 8'hC2, 1'b1);
    ex(3, 8'hC1); ex(3, 8'hC2);
    k = 0;
    while (trig_cnt == t0 && k < 20) begin @(negedge clk); k++; end
    k = 0;
    while (!tx_busy && k < 10) begin @(negedge clk); k++; end
    viol = 0;
    k = 0;
    while (tx_busy && k < 100) begin
      @(negedge clk); k++;
      if (tx_busy && (req_ready_out != '0 || tx_trigger_out)) viol++;
    end
    chk("t4_gate_violations", 32'(viol), 32'd0);
    k = 0;
    while (!tx_trigger_out && k < 10) begin @(negedge clk); k++; end
    chk("t4_gap_after_busy", 32'(k), 32'd2);
    wait_idle("t4", 400);
    busy_len = 20;

    // Start timeout with busy stuck low.
    stuck = 1'b1;
    @(negedge clk);
    t0 = trig_cnt;
    pw(1, 8'h77, 1'b1); ex(1, 8'h77);
    k = 0;
    while (!tx_trigger_out && k < 20) begin @(negedge clk); k++; end
    k = 0;
    while (!timeout_err_out && k < 40) begin @(negedge clk); k++; end
    chk("t5_timeout_cycles", 32'(k), 32'(TO));
    wait_idle("t5a", 100);
    pw(2, 8'h88, 1'b1); ex(2, 8'h88);
    wait_idle("t5b", 100);
    chk("t5_err_sticky", 32'(timeout_err_out), 32'd1);
    chk("t5_trig_count", 32'(trig_cnt - t0), 32'd2);
    stuck = 1'b0;

    // Reset during WAIT_DONE of beat 2 of 3.
    @(negedge clk);
    t0 = trig_cnt;
    pw(2, 8'hA1, 1'b0); pw(2, 8'hA2, 1'b0); pw(2, 8'hA3, 1'b1);
    ex(2, 8'hA1); ex(2, 8'hA2);
    k = 0;
    while (trig_cnt < t0 + 2 && k < 200) begin @(negedge clk); k++; end
    chk("t6_reached_beat2", 32'(trig_cnt - t0), 32'd2);
    k = 0;
    while (!tx_busy && k < 10) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    do_reset("rst_mid");
    t0 = trig_cnt;
    repeat (5) @(negedge clk);
    chk("t6_no_trig_after_release", 32'(trig_cnt - t0), 32'd0);
    chk("t6_idle_grant", 32'(grant_out), 32'd0);
    pw(3, 8'hD3, 1'b1); pw(0, 8'hD0, 1'b1);
    ex(0, 8'hD0); ex(3, 8'hD3);
    k = 0;
    while (grant_out == '0 && k < 20) begin @(negedge clk); k++; end
    chk("t6_first_grant", 32'(grant_out), 32'b0001);
    wait_idle("t6", 300);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (trigger/busy interface, DATA_SIZE-bit words) among NUM_REQ requesters.
- Grants are round-robin and packet-locked: a granted requester keeps the transmitter until it sends a beat flagged last.
- The block sequences each word into the transmitter and waits for the transmitter's busy cycle to complete before accepting the next word.
- Sits between the on-chip status/result producers and the serial link back to the host.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_SIZE, 8, word width passed to the transmitter.
- START_TIMEOUT, 16, maximum cycles to wait for tx_busy_in to rise after a trigger.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  NUM_REQ  per-requester word valid.
- req_data_in  input  NUM_REQ*DATA_SIZE  per-requester word; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_last_in  input  NUM_REQ  per-requester end-of-packet flag, qualified by valid.
- req_ready_out  output  NUM_REQ  per-requester accept strobe.
- tx_data_out  output  DATA_SIZE  word to the transmitter.
- tx_trigger_out  output  1  one-cycle start pulse to the transmitter.
- tx_busy_in  input  1  transmitter busy.
- grant_out  output  NUM_REQ  one-hot current owner; 0 when no owner.
- timeout_err_out  output  1  sticky flag: busy never rose after a trigger.

Behaviour:
- Reset (async assert, sync release):
  - State ARB, owner none, grant_out=0.
  - req_ready_out=0, tx_trigger_out=0, tx_data_out=0, timeout_err_out=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-packet abandons the packet; no trigger is issued after release until a new arbitration.
- States:
  - ARB:
    - If any req_valid_in is set, pick the first set bit scanning ptr+1, ptr+2, ... (mod NUM_REQ).
    - Register owner and grant_out, then go to SEND.
    - Otherwise stay.
    - Arbitration takes exactly one cycle.
  - SEND:
    - req_ready_out[owner]=1 combinationally; all other ready bits are 0.
    - If req_valid_in[owner] is set, the beat is accepted that cycle:
      - tx_data_out <= owner word.
      - tx_trigger_out <= 1 (next cycle only).
      - last_r <= req_last_in[owner].
      - Clear the timeout counter and go to WAIT_START.
    - If valid is low, hold the grant and stay; the owner is never preempted mid-packet.
  - WAIT_START:
    - tx_trigger_out drops after one cycle.
    - If tx_busy_in=1, go to WAIT_DONE.
    - Otherwise increment the counter. When it reaches START_TIMEOUT, set timeout_err_out and treat the word as done (same exit as WAIT_DONE with busy low).
  - WAIT_DONE:
    - On tx_busy_in=0: if last_r, set ptr <= owner, grant_out <= 0 and go to ARB; else go to SEND.
- Latency:
  - Valid seen in ARB at cycle t: grant at t+1, ready and accept at t+1, tx_trigger_out high at t+2.
  - Minimum inter-word gap is bounded by the transmitter busy time plus 2 cycles.
- Ready never asserts while a word is in flight, so at most one word is outstanding.
- tx_data_out holds its value until the next accept.
- If tx_busy_in is already high in SEND (stale), the word is still issued; the bench treats this as a transmitter protocol violation.
- Simultaneous requests: only the RR winner is granted. Losers see ready=0 and must hold valid/data stable.
- Owner drops valid mid-packet: the grant is held indefinitely (intended packet lock).
- Single-beat packet (last on the first beat): the grant is released after that word.
- Pointer wrap: after owner NUM_REQ-1, the scan starts at 0.
- timeout_err_out clears only on reset.

Test Plan:
- Single requester: req1 sends 8'hA5 with last=1 (transmitter model busy 20 cycles, rising 2 cycles after trigger) -> grant_out=4'b0010, exactly one trigger with tx_data_out=8'hA5, grant_out=0 after busy falls, timeout_err_out=0.
- Round-robin: req0..req3 all valid with 1-word packets, held continuously -> grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Packet lock: req2 sends 3 words (8'h11, 8'h22, 8'h33 with last on the third) while req0 is also valid -> three triggers in order 11, 22, 33 from req2 only; req0 granted afterwards.
- Busy gating: hold tx_busy_in high 50 cycles after the first trigger -> req_ready_out stays 0 and no second trigger until busy falls; then the next word is issued within 2 cycles.
- Timeout: tx_busy_in tied 0 -> timeout_err_out rises START_TIMEOUT=16 cycles after the trigger, the arbiter proceeds, and the flag stays set.
- Async reset mid-packet: assert rst_n_in=0 during WAIT_DONE of word 2 of 3 -> all outputs 0 immediately; after release req0 wins the first arbitration.
